// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Character write port into the UART transmit FIFO (valid/ready handshake).
//   wdata_i  : character to enqueue, LSB is sent first on the line
//   wvalid_i : write request from the register block
//   wready_o : FIFO can accept the write this cycle
// master modport = register block side, slave modport = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int unsigned MAX_DATA_W = 9
);
  logic [MAX_DATA_W-1:0] wdata_i;
  logic                  wvalid_i;
  logic                  wready_o;

  modport master (
    output wdata_i,
    output wvalid_i,
    input  wready_o
  );

  modport slave (
    input  wdata_i,
    input  wvalid_i,
    output wready_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an integrated transmit FIFO. Characters arrive over
// the wr_if write port, are buffered, and are serialised onto tx_o with one
// bit per clk_en_i tick. Supports 5..MAX_DATA_W data bits, none/even/odd/
// mark/space parity, 1 or 2 stop bits, break generation and FIFO flush.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clk_en_i          : baud tick, one cycle per bit period
//   en_i              : transmitter enable (gates frame start only)
//   data_size_i       : data bits per frame (clamped to 5..MAX_DATA_W)
//   parity_mode_i     : 0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//   stop_size_i       : 0/1 -> 1 stop bit, 2/3 -> 2 stop bits
//   wr_if             : character write port (slave)
//   flush_i           : empty the FIFO
//   break_i           : hold the line low once idle
//   tx_o              : serial line, idle high
//   busy_o            : frame or break in progress
//   fifo_level_o      : entries held
//   empty_o, full_o   : FIFO status
//   overflow_o        : one-cycle pulse after a write attempt while full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_DATA_W = 9
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clk_en_i,
  input  logic                            en_i,
  input  logic [3:0]                      data_size_i,
  input  logic [2:0]                      parity_mode_i,
  input  logic [1:0]                      stop_size_i,
  uart_tx_fifo_if.slave                   wr_if,
  input  logic                            flush_i,
  input  logic                            break_i,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic                            overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // FIFO storage and status
  logic [MAX_DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_count;
  logic                  r_overflow;

  // Frame registers, latched at frame start
  logic [MAX_DATA_W-1:0] r_data;
  logic [3:0]            r_nbits;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_two_stop;

  // Serialiser state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_bit_idx;
  logic [3:0]            w_bit_idx_nxt;
  logic                  r_stop_left;
  logic                  w_stop_left_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wready;
  logic                  w_push;
  logic                  w_start;
  logic                  w_can_start;
  logic [MAX_DATA_W-1:0] w_rdata;
  logic [3:0]            w_nbits;
  logic [MAX_DATA_W-1:0] w_mask;
  logic                  w_xor;
  logic                  w_par_en;
  logic                  w_par_bit;
  logic [MAX_DATA_W-1:0] w_shift;

  assign w_empty  = (r_count == LW'(0));
  assign w_full   = (r_count == LW'(FIFO_DEPTH));
  assign w_wready = ~w_full & ~flush_i;
  assign w_push   = wr_if.wvalid_i & w_wready;
  assign w_rdata  = r_mem[r_rptr];

  assign w_can_start = en_i & ~w_empty & ~break_i;

  // Clamp the requested width and derive parity for the head-of-FIFO word
  always_comb begin
    w_nbits   = data_size_i;
    w_mask    = '0;
    w_par_en  = 1'b0;
    w_par_bit = 1'b0;
    if (data_size_i < 4'd5) begin
      w_nbits = 4'd5;
    end else if (data_size_i > 4'(MAX_DATA_W)) begin
      w_nbits = 4'(MAX_DATA_W);
    end
    for (int i = 0; i < int'(MAX_DATA_W); i++) begin
      w_mask[i] = (i < int'(w_nbits));
    end
    w_xor = ^(w_rdata & w_mask);
    case (parity_mode_i)
      3'd1: begin w_par_en = 1'b1; w_par_bit = w_xor;  end
      3'd2: begin w_par_en = 1'b1; w_par_bit = ~w_xor; end
      3'd3: begin w_par_en = 1'b1; w_par_bit = 1'b1;   end
      3'd4: begin w_par_en = 1'b1; w_par_bit = 1'b0;   end
      default: begin w_par_en = 1'b0; w_par_bit = 1'b0; end
    endcase
  end

  // Next-state logic; the final stop tick may chain straight into the next
  // frame (or break) so consecutive frames carry no idle bit between them
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_idx_nxt   = r_bit_idx;
    w_stop_left_nxt = r_stop_left;
    w_start         = 1'b0;
    if (clk_en_i) begin
      case (r_state)
        S_IDLE: begin
          if (break_i) begin
            w_state_nxt = S_BREAK;
          end else if (w_can_start) begin
            w_state_nxt = S_START;
            w_start     = 1'b1;
          end
        end
        S_START: begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 4'd0;
        end
        S_DATA: begin
          if (r_bit_idx == (r_nbits - 4'd1)) begin
            w_state_nxt     = r_par_en ? S_PARITY : S_STOP;
            w_stop_left_nxt = r_two_stop;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end
        S_PARITY: begin
          w_state_nxt     = S_STOP;
          w_stop_left_nxt = r_two_stop;
        end
        S_STOP: begin
          if (r_stop_left) begin
            w_stop_left_nxt = 1'b0;
          end else if (break_i) begin
            w_state_nxt = S_BREAK;
          end else if (w_can_start) begin
            w_state_nxt = S_START;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_BREAK: begin
          // Release always sends exactly one mark tick
          if (!break_i) begin
            w_state_nxt     = S_STOP;
            w_stop_left_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Line level for the state being entered
  always_comb begin
    w_shift  = r_data >> w_bit_idx_nxt;
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift[0];
      S_PARITY: w_tx_nxt = r_par_bit;
      S_BREAK:  w_tx_nxt = 1'b0;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Serialiser registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_bit_idx   <= 4'd0;
      r_stop_left <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_data      <= '0;
      r_nbits     <= 4'd5;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_two_stop  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_stop_left <= w_stop_left_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_start) begin
        r_data     <= w_rdata;
        r_nbits    <= w_nbits;
        r_par_en   <= w_par_en;
        r_par_bit  <= w_par_bit;
        r_two_stop <= stop_size_i[1];
      end
    end
  end

  // FIFO pointers, level and overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_if.wvalid_i & w_full & ~flush_i;
      if (flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_start) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + LW'(w_push) - LW'(w_start);
      end
    end
  end

  // FIFO storage needs no reset; only written on an accepted push
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_if.wdata_i;
    end
  end

  assign wr_if.wready_o = w_wready;
  assign tx_o           = r_tx;
  assign busy_o         = r_busy;
  assign fifo_level_o   = r_count;
  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign overflow_o     = r_overflow;

endmodule
